pq_reg_array: RTL

Register-array min-priority queue that serves the `pq_rd_if` server side. It holds up to `DEPTH` key/value entries sorted by key and always presents the smallest-key entry on `kvo`. It accepts insert (`replace`), remove-head (`deq`), or both at once (true replace), using a fixed two-cycle accept/commit handshake flagged by `busy`. It is the queue exercised by the automatic random-enqueue/ordered-dequeue test harness.

---
 rtl/pq_pkg.sv | 17 +
 rtl/pq_ra_cell.sv | 42 ++++
 rtl/pq_reg_array.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the register-array priority queue.
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  localparam kv_t KV_EMPTY = kv_t'(16'hFFFF);

  typedef enum logic {IDLE, ACCEPT} pq_state_t;

  // Per-slot next-value source: left = toward head (i-1), right = toward tail (i+1).
  typedef enum logic [1:0] {SEL_HOLD, SEL_LEFT, SEL_RIGHT, SEL_KVI} cell_sel_t;
endpackage

// File: rtl/pq_ra_cell.sv
// One queue slot: stored entry, valid bit, key compare and next-value mux.
module pq_ra_cell
  import pq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  cell_sel_t sel,
  input  kv_t       kvi,
  input  kv_t       left_kv,
  input  logic      left_valid,
  input  kv_t       right_kv,
  input  logic      right_valid,
  output kv_t       kv,
  output logic      valid,
  output logic      gt
);
  // Empty slots behave as +infinity so the insert point is always found.
  assign gt = !valid || (kv.key > kvi.key);

  always_ff @(posedge clk) begin
    if (rst) begin
      kv    <= KV_EMPTY;
      valid <= 1'b0;
    end else begin
      unique case (sel)
        SEL_LEFT: begin
          kv    <= left_kv;
          valid <= left_valid;
        end
        SEL_RIGHT: begin
          kv    <= right_kv;
          valid <= right_valid;
        end
        SEL_KVI: begin
          kv    <= kvi;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pq_reg_array.sv
// Sorted register-array min-priority queue with two-cycle accept/commit.
// Optional sticky illegal-request flag enabled by defining PQ_ERR_EN.
module pq_reg_array
  import pq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic replace,
  input  logic deq,
  input  kv_t  kvi,
  output kv_t  kvo,
  output logic full,
  output logic empty,
  output logic busy
`ifdef PQ_ERR_EN
  ,
  output logic err
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pq_state_t        state, state_nxt;
  logic             op_ins, op_deq;
  kv_t              op_kv;
  logic [CNT_W-1:0] count, count_nxt;
  logic             sample_ins, sample_deq, take;
  logic [CNT_W-1:0] ins_pos, rep_pos;

  kv_t              slot_kv    [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_gt;
  cell_sel_t        slot_sel   [DEPTH];

  always_comb begin
    // Replace+deq on an empty queue degrades to a plain insert.
    sample_ins = replace && (deq || !full);
    sample_deq = deq && !empty;
    take       = (state == IDLE) && (sample_ins || sample_deq);
    state_nxt  = state;
    unique case (state)
      IDLE:    if (take) state_nxt = ACCEPT;
      ACCEPT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ins_pos = CNT_W'(DEPTH);
    rep_pos = CNT_W'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) if (slot_gt[i]) ins_pos = CNT_W'(i);
    // For true replace the head leaves, so only slots 1.. are candidates.
    for (int i = DEPTH - 1; i >= 1; i--) if (slot_gt[i]) rep_pos = CNT_W'(i);
    for (int i = 0; i < DEPTH; i++) begin
      slot_sel[i] = SEL_HOLD;
      if (state == ACCEPT) begin
        if (op_ins && op_deq) begin
          if (i < int'(rep_pos) - 1)       slot_sel[i] = SEL_RIGHT;
          else if (i == int'(rep_pos) - 1) slot_sel[i] = SEL_KVI;
        end else if (op_ins) begin
          if (i == int'(ins_pos))     slot_sel[i] = SEL_KVI;
          else if (i > int'(ins_pos)) slot_sel[i] = SEL_LEFT;
        end else if (op_deq) begin
          slot_sel[i] = SEL_RIGHT;
        end
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (op_ins && !op_deq)      count_nxt = count + 1'b1;
    else if (op_deq && !op_ins) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_ins <= 1'b0;
      op_deq <= 1'b0;
      op_kv  <= KV_EMPTY;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_ins <= sample_ins;
        op_deq <= sample_deq;
        op_kv  <= kvi;
      end
      if (state == ACCEPT) begin
        count <= count_nxt;
        full  <= (count_nxt == CNT_W'(DEPTH));
        empty <= (count_nxt == '0);
      end
    end
  end

  assign busy = (state == ACCEPT);
  assign kvo  = slot_kv[0];

`ifdef PQ_ERR_EN
  logic illegal;
  assign illegal = (state == IDLE) &&
                   ((replace && !deq && full) || (deq && !replace && empty));

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    kv_t  l_kv, r_kv;
    logic l_v, r_v;
    if (g == 0) begin : g_head
      assign l_kv = KV_EMPTY;
      assign l_v  = 1'b0;
    end else begin : g_mid_l
      assign l_kv = slot_kv[g-1];
      assign l_v  = slot_valid[g-1];
    end
    if (g == DEPTH - 1) begin : g_tail
      assign r_kv = KV_EMPTY;
      assign r_v  = 1'b0;
    end else begin : g_mid_r
      assign r_kv = slot_kv[g+1];
      assign r_v  = slot_valid[g+1];
    end

    pq_ra_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .sel         (slot_sel[g]),
      .kvi         (op_kv),
      .left_kv     (l_kv),
      .left_valid  (l_v),
      .right_kv    (r_kv),
      .right_valid (r_v),
      .kv          (slot_kv[g]),
      .valid       (slot_valid[g]),
      .gt          (slot_gt[g])
    );
  end
endmodule
